// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing/pattern generator: pattern modes, FSM states and
// the colour-bar table.
package lcd_pkg;

  localparam logic [2:0] MODE_SOLID = 3'd0;
  localparam logic [2:0] MODE_BARS  = 3'd1;
  localparam logic [2:0] MODE_GRAD  = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_MOVE  = 3'd4;
  localparam logic [2:0] MODE_BLACK = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Channel enables {r,g,b} for colour bar idx, leftmost bar first.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    logic [2:0] c;
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_pixel.sv
// Combinational test-pattern pixel: maps (x, y, mode, moving-bar offset) to one {r,g,b} pixel.
module lcd_pattern_pixel
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1366,
  parameter int unsigned COLOR_W    = 6,
  parameter int unsigned GRAD_SHIFT = 4,
  parameter int unsigned CHK_SHIFT  = 5
) (
  input  logic [15:0]          x,
  input  logic [15:0]          y,
  input  logic [2:0]           mode,
  input  logic [15:0]          offset,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [3*COLOR_W-1:0] pix
);

  localparam int unsigned Bar = H_ACTIVE / 8;

  logic [2:0]         bar_idx;
  logic [2:0]         bar_c;
  logic [COLOR_W-1:0] grad;
  logic               chk_on;
  logic               move_on;

  always_comb begin
    // Bars beyond the seventh boundary all land on index 7 (black).
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 16'(i * Bar)) bar_idx = 3'(i);
    end
    bar_c   = bar_color(bar_idx);
    grad    = COLOR_W'(x >> GRAD_SHIFT);
    chk_on  = 1'((x >> CHK_SHIFT) ^ (y >> CHK_SHIFT));
    move_on = ({1'b0, x} >= {1'b0, offset}) && ({1'b0, x} < ({1'b0, offset} + 17'd16));

    case (mode)
      MODE_SOLID: pix = solid_rgb;
      MODE_BARS:  pix = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
      MODE_GRAD:  pix = {3{grad}};
      MODE_CHECK: pix = chk_on ? '1 : '0;
      MODE_MOVE:  pix = move_on ? '1 : '0;
      default:    pix = '0;
    endcase
  end

endmodule

// File: rtl/lcd_timing_pattern_gen.sv
// Raster timing generator and test-pattern source for LVDS LCD panels, 1 or 2 pixels/clock.
// Optional packed serializer output enabled by LCD_TPG_LVDS_PACK_EN.
module lcd_timing_pattern_gen
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1366,
  parameter int unsigned H_FP       = 14,
  parameter int unsigned H_SYNC     = 56,
  parameter int unsigned H_BP       = 104,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 4,
  parameter int unsigned COLOR_W    = 6,
  parameter int unsigned PPC        = 1,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned GRAD_SHIFT = 4,
  parameter int unsigned CHK_SHIFT  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [2:0]                 mode,
  input  logic [3*COLOR_W-1:0]       solid_rgb,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       de,
  output logic [PPC*3*COLOR_W-1:0]   rgb,
  output logic                       frame_start,
  output logic [15:0]                frame_cnt,
  output logic                       busy
`ifdef LCD_TPG_LVDS_PACK_EN
  ,
  output logic [PPC*21-1:0]          lvds_data
`endif
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW = 3 * COLOR_W;

  localparam logic [15:0] HLast  = 16'(HT / PPC - 1);
  localparam logic [15:0] HAct   = 16'(H_ACTIVE / PPC);
  localparam logic [15:0] HSyncS = 16'((H_ACTIVE + H_FP) / PPC);
  localparam logic [15:0] HSyncE = 16'((H_ACTIVE + H_FP + H_SYNC) / PPC);
  localparam logic [15:0] VLast  = 16'(VT - 1);
  localparam logic [15:0] VAct   = 16'(V_ACTIVE);
  localparam logic [15:0] VSyncS = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VSyncE = 16'(V_ACTIVE + V_FP + V_SYNC);

  state_e state_q, state_d;

  logic [15:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] offset_q, offset_d, offset_step;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        first_q, first_d;

  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [PPC*PW-1:0] rgb_q, rgb_d, pix_all;

  logic running, fs_now, h_last, frame_last;

  assign h_last     = (hcnt_q == HLast);
  assign frame_last = h_last && (vcnt_q == VLast);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      // Dropping enable on the very last cycle finishes the frame immediately.
      StRun:   if (!enable) state_d = frame_last ? StIdle : StDrain;
      StDrain: begin
        if (enable)          state_d = StRun;
        else if (frame_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running = (state_q != StIdle);
    busy    = (state_q == StRun);
    fs_now  = (state_q == StRun) && (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_comb begin
    hcnt_d = '0;
    vcnt_d = '0;
    if (running) begin
      hcnt_d = h_last ? '0 : hcnt_q + 16'd1;
      vcnt_d = vcnt_q;
      if (h_last) vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 16'd1;
    end

    first_d = first_q;
    if (!running)    first_d = 1'b1;
    else if (fs_now) first_d = 1'b0;

    offset_step = (({1'b0, offset_q} + 17'd20) > 17'(H_ACTIVE)) ? '0 : offset_q + 16'd4;
    // The frame-start pixel already uses the newly latched mode and offset.
    mode_d      = fs_now ? mode : mode_q;
    offset_d    = fs_now ? offset_step : offset_q;
    frame_cnt_d = frame_cnt_q + 16'(fs_now && !first_q);

    de_d  = running && (hcnt_q < HAct) && (vcnt_q < VAct);
    hs_d  = (running && (hcnt_q >= HSyncS) && (hcnt_q < HSyncE)) ? HS_POL : ~HS_POL;
    vs_d  = (running && (vcnt_q >= VSyncS) && (vcnt_q < VSyncE)) ? VS_POL : ~VS_POL;
    fs_d  = fs_now;
    rgb_d = de_d ? pix_all : '0;
  end

  for (genvar k = 0; k < PPC; k++) begin : g_pix
    logic [15:0] x_k;
    assign x_k = 16'(32'(hcnt_q) * PPC + k);

    lcd_pattern_pixel #(
      .H_ACTIVE  (H_ACTIVE),
      .COLOR_W   (COLOR_W),
      .GRAD_SHIFT(GRAD_SHIFT),
      .CHK_SHIFT (CHK_SHIFT)
    ) u_pix (
      .x        (x_k),
      .y        (vcnt_q),
      .mode     (mode_d),
      .offset   (offset_d),
      .solid_rgb(solid_rgb),
      .pix      (pix_all[k*PW +: PW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      mode_q      <= '0;
      offset_q    <= '0;
      frame_cnt_q <= '0;
      first_q     <= 1'b1;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      mode_q      <= mode_d;
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
      first_q     <= first_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      rgb_q       <= rgb_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

`ifdef LCD_TPG_LVDS_PACK_EN
  // Word = {pair2, pair1, pair0}, which collapses to {de, vs, hs, b6, g6, r6}.
  for (genvar k = 0; k < PPC; k++) begin : g_lvds
    logic [5:0] r6, g6, b6;
    assign r6 = rgb_q[k*PW + 3*COLOR_W - 1 -: 6];
    assign g6 = rgb_q[k*PW + 2*COLOR_W - 1 -: 6];
    assign b6 = rgb_q[k*PW + COLOR_W - 1 -: 6];
    assign lvds_data[k*21 +: 21] = {de_q, vs_q, hs_q, b6, g6, r6};
  end
`endif

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench for lcd_timing_pattern_gen: small raster, pattern vector table, FSM sequences,
// plus a 2-pixel-per-clock instance.
module tb_lcd_timing_pattern_gen;

  localparam int CW = 6;
  localparam int PW = 3 * CW;
  localparam int HT = 24;
  localparam int FRAME = 192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [PW-1:0] solid_rgb = 18'h2A5C3;
  logic          hsync, vsync, de, frame_start, busy;
  logic [PW-1:0] rgb;
  logic [15:0]   frame_cnt;

  logic            enable2 = 1'b0;
  logic [2:0]      mode2 = 3'd2;
  logic            hsync2, vsync2, de2, frame_start2, busy2;
  logic [2*PW-1:0] rgb2;
  logic [15:0]     frame_cnt2;
`ifdef LCD_TPG_LVDS_PACK_EN
  logic [20:0] lvds1;
  logic [41:0] lvds2;
`endif

  always #5 clk = ~clk;

  lcd_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_W(CW), .PPC(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .GRAD_SHIFT(1), .CHK_SHIFT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .busy(busy)
`ifdef LCD_TPG_LVDS_PACK_EN
    , .lvds_data(lvds1)
`endif
  );

  lcd_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .COLOR_W(CW), .PPC(2), .HS_POL(1'b0), .VS_POL(1'b0),
    .GRAD_SHIFT(0), .CHK_SHIFT(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable2), .mode(mode2), .solid_rgb(solid_rgb),
    .hsync(hsync2), .vsync(vsync2), .de(de2), .rgb(rgb2), .frame_start(frame_start2),
    .frame_cnt(frame_cnt2), .busy(busy2)
`ifdef LCD_TPG_LVDS_PACK_EN
    , .lvds_data(lvds2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (frame_start !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: frame_start missing after 400 cycles, expected a pulse", name);
    end
  endtask

  typedef struct {
    logic [2:0]    mode;
    int            x;
    int            y;
    logic [PW-1:0] rgb;
    logic          de;
  } vec_t;

  vec_t vecs[$];

  int x, y, de_cnt, de_line0, hs_low, vs_low, pos_bad, extra_fs, first_hs, first_vs, fs_cnt;
  logic exp_de, exp_hs, exp_vs;
  logic [15:0] fc0;

  initial begin
    vecs.push_back('{3'd0, 3, 1, 18'h2A5C3, 1'b1});
    vecs.push_back('{3'd0, 17, 0, 18'h00000, 1'b0});
    vecs.push_back('{3'd1, 0, 0, 18'h3FFFF, 1'b1});
    vecs.push_back('{3'd1, 1, 0, 18'h3FFFF, 1'b1});
    vecs.push_back('{3'd1, 2, 0, 18'h3FFC0, 1'b1});
    vecs.push_back('{3'd1, 3, 0, 18'h3FFC0, 1'b1});
    vecs.push_back('{3'd1, 4, 1, 18'h00FFF, 1'b1});
    vecs.push_back('{3'd1, 6, 1, 18'h00FC0, 1'b1});
    vecs.push_back('{3'd1, 8, 2, 18'h3F03F, 1'b1});
    vecs.push_back('{3'd1, 10, 2, 18'h3F000, 1'b1});
    vecs.push_back('{3'd1, 12, 3, 18'h0003F, 1'b1});
    vecs.push_back('{3'd1, 14, 3, 18'h00000, 1'b1});
    vecs.push_back('{3'd1, 15, 3, 18'h00000, 1'b1});
    vecs.push_back('{3'd2, 5, 0, 18'h02082, 1'b1});
    vecs.push_back('{3'd2, 15, 1, 18'h071C7, 1'b1});
    vecs.push_back('{3'd3, 0, 0, 18'h00000, 1'b1});
    vecs.push_back('{3'd3, 4, 0, 18'h3FFFF, 1'b1});
    vecs.push_back('{3'd3, 4, 3, 18'h3FFFF, 1'b1});
    vecs.push_back('{3'd3, 8, 1, 18'h00000, 1'b1});
    vecs.push_back('{3'd3, 12, 2, 18'h3FFFF, 1'b1});
    vecs.push_back('{3'd3, 4, 4, 18'h00000, 1'b0});
    vecs.push_back('{3'd4, 7, 2, 18'h3FFFF, 1'b1});
    vecs.push_back('{3'd5, 3, 1, 18'h00000, 1'b1});

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_de", de, 1'b0);
    check("rst_rgb", rgb, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    enable2 = 1'b1;

    repeat (3) @(negedge clk);
    check("idle_de", de, 1'b0);
    check("idle_fs", frame_start, 1'b0);

    // Start: frame_start two edges after enable is seen
    enable = 1'b1;
    @(negedge clk);
    check("start_fs_early", frame_start, 1'b0);
    check("start_busy", busy, 1'b1);
    @(negedge clk);
    check("start_fs", frame_start, 1'b1);
    check("start_de", de, 1'b1);
    check("start_rgb", rgb, solid_rgb);
    check("first_frame_cnt", frame_cnt, 0);

    // Full-frame timing scan
    de_cnt = 0; de_line0 = 0; hs_low = 0; vs_low = 0; pos_bad = 0; extra_fs = 0;
    first_hs = -1; first_vs = -1;
    for (int i = 0; i < FRAME; i++) begin
      x = i % HT;
      y = i / HT;
      exp_de = (x < 16) && (y < 4);
      exp_hs = !((x >= 18) && (x < 21));
      exp_vs = !((y >= 5) && (y < 7));
      if (de !== exp_de || hsync !== exp_hs || vsync !== exp_vs) pos_bad++;
      if (de === 1'b1) de_cnt++;
      if (de === 1'b1 && y == 0) de_line0++;
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (hsync === 1'b0 && first_hs < 0) first_hs = i;
      if (vsync === 1'b0 && first_vs < 0) first_vs = i;
      if (i > 0 && frame_start === 1'b1) extra_fs++;
      @(negedge clk);
    end
    check("scan_positions", pos_bad, 0);
    check("de_per_frame", de_cnt, 64);
    check("de_per_line", de_line0, 16);
    check("hsync_low_cycles", hs_low, 24);
    check("hsync_first_low_x", first_hs, 18);
    check("vsync_low_cycles", vs_low, 48);
    check("vsync_first_line", first_vs / HT, 5);
    check("extra_frame_start", extra_fs, 0);
    check("frame_period", frame_start, 1'b1);
    check("frame_cnt_after_1", frame_cnt, 1);

    // Pattern vector table
    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      wait_fs("vec_sync");
      wait_fs("vec_sync");
      repeat (vecs[i].y * HT + vecs[i].x) @(negedge clk);
      check($sformatf("vec%0d_m%0d_x%0d_y%0d_rgb", i, vecs[i].mode, vecs[i].x, vecs[i].y),
            rgb, vecs[i].rgb);
      check($sformatf("vec%0d_de", i), de, vecs[i].de);
    end

    // Mode change mid-frame takes effect at the next frame start
    mode = 3'd0;
    wait_fs("mc_sync");
    wait_fs("mc_sync");
    fc0 = frame_cnt;
    repeat (HT + 4) @(negedge clk);
    check("mc_before", rgb, solid_rgb);
    mode = 3'd3;
    repeat (HT) @(negedge clk);
    check("mc_same_frame", rgb, solid_rgb);
    wait_fs("mc_next");
    check("mc_frame_cnt_1", frame_cnt, fc0 + 16'd1);
    repeat (4) @(negedge clk);
    check("mc_new_pattern", rgb, 18'h3FFFF);
    wait_fs("mc_next2");
    check("mc_frame_cnt_2", frame_cnt, fc0 + 16'd2);

    // PPC=2 instance
    wait_fs2_block : begin
      int j;
      j = 0;
      @(negedge clk);
      while (frame_start2 !== 1'b1 && j < 400) begin
        @(negedge clk);
        j++;
      end
    end
    check("ppc2_fs_seen", frame_start2, 1'b1);
    de_cnt = 0; de_line0 = 0;
    for (int i = 0; i < 96; i++) begin
      if (i == 0) check("ppc2_px01", rgb2, {18'h01041, 18'h00000});
      if (i == 3) check("ppc2_px67", rgb2, {18'h071C7, 18'h06186});
      if (de2 === 1'b1) de_cnt++;
      if (de2 === 1'b1 && i < 12) de_line0++;
      @(negedge clk);
    end
    check("ppc2_de_line", de_line0, 8);
    check("ppc2_de_frame", de_cnt, 32);
    check("ppc2_period", frame_start2, 1'b1);

    // Deassert enable mid-frame: the frame completes, then idle
    mode = 3'd0;
    wait_fs("drain_sync");
    repeat (2 * HT) @(negedge clk);
    enable = 1'b0;
    de_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (de === 1'b1) de_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("drain_de_cycles", de_cnt, 31);
    check("drain_no_fs", fs_cnt, 0);
    check("drain_busy", busy, 1'b0);
    check("drain_de", de, 1'b0);
    check("drain_hsync", hsync, 1'b1);
    check("drain_vsync", vsync, 1'b1);
    check("drain_rgb", rgb, 0);

    // Reassert enable
    enable = 1'b1;
    @(negedge clk);
    check("restart_fs_early", frame_start, 1'b0);
    @(negedge clk);
    check("restart_fs", frame_start, 1'b1);

    // Asynchronous reset mid-line
    repeat (5) @(negedge clk);
    check("pre_rst_de", de, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_de", de, 1'b0);
    check("async_rst_rgb", rgb, 0);
    check("async_rst_hsync", hsync, 1'b1);
    check("async_rst_vsync", vsync, 1'b1);
    check("async_rst_frame_cnt", frame_cnt, 0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_fs", frame_start, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2000000, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_timing_pattern_gen.md
Name: lcd_timing_pattern_gen

Overview:
- Parametrised raster timing generator and test-pattern source for LVDS LCD panels.
- Successor to the fixed 1366x768 single-pattern generator. Adds generic timing, 1 or 2 pixels per clock, selectable sync polarity, six runtime-selectable patterns, and a frame counter.
- Sits in the pixel-clock domain and feeds the 7:1 serializer's video data bus.

Parameters:
- H_ACTIVE, 1366, active pixels per line
- H_FP, 14, horizontal front porch in pixels
- H_SYNC, 56, hsync width in pixels
- H_BP, 104, horizontal back porch in pixels
- V_ACTIVE, 768, active lines
- V_FP, 3, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- V_BP, 4, vertical back porch in lines
- COLOR_W, 6, bits per colour component
- PPC, 1, pixels per clock (1 or 2); with PPC=2 all H_* parameters must be even
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- GRAD_SHIFT, 4, gradient step = 2^GRAD_SHIFT pixels
- CHK_SHIFT, 5, checker square = 2^CHK_SHIFT pixels

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request
- mode  in  3  pattern select, sampled at frame start
- solid_rgb  in  3*COLOR_W  colour for mode 0, as {r,g,b}
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- de  out  1  data enable
- rgb  out  PPC*3*COLOR_W  pixel data; pixel k occupies bits [(k+1)*3*COLOR_W-1 : k*3*COLOR_W], each pixel {r,g,b}
- frame_start  out  1  one-cycle pulse aligned with the first active pixel of a frame
- frame_cnt  out  16  completed frames, wraps at 2^16
- busy  out  1  high while in state RUN

Behaviour:
- Totals: HT = H_ACTIVE+H_FP+H_SYNC+H_BP, VT = V_ACTIVE+V_FP+V_SYNC+V_BP. hcnt counts 0..HT/PPC-1; vcnt counts 0..VT-1.
- hcnt wraps to 0 at HT/PPC-1. vcnt increments on each hcnt wrap and wraps to 0 at VT-1. There is no extra cycle at either end.
- Pixel x = hcnt*PPC+k (k = 0..PPC-1); line y = vcnt.
- Intervals (in clock units; H values divided by PPC):
  - de: hcnt < H_ACTIVE and vcnt < V_ACTIVE
  - hsync active: H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, on all lines
  - vsync active: V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC
- All outputs are registered with exactly 1 cycle latency from the counters, and hsync, vsync, de and rgb stay mutually aligned.
- rgb is all zero whenever de is 0.
- State machine:
  - IDLE: counters held at 0; hsync and vsync inactive; de=0; rgb=0. Go to RUN when enable=1.
  - RUN: counters free-run. If enable=0, go to DRAIN.
  - DRAIN: continue until the last cycle of the frame (hcnt=HT/PPC-1, vcnt=VT-1), then go to IDLE. If enable returns to 1 during DRAIN, go back to RUN with no glitch.
- Frame start (hcnt=0, vcnt=0 in RUN):
  - mode is latched to mode_q.
  - frame_start pulses, aligned with the first de.
  - Previous frame_cnt is incremented, except on the first frame after leaving IDLE.
  - Moving-bar offset advances by 4 pixels, and wraps to 0 when offset+4 > H_ACTIVE-16.
- Patterns (by mode_q):
  - 0: solid_rgb
  - 1: 8 vertical colour bars, each BAR=H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. Pixels with x >= 7*BAR are black.
  - 2: grey gradient; r=g=b=(x>>GRAD_SHIFT) truncated to COLOR_W bits.
  - 3: checkerboard; white if ((x>>CHK_SHIFT)^(y>>CHK_SHIFT))[0] is 1, else black.
  - 4: moving white vertical bar, 16 pixels wide, at offset <= x < offset+16, on a black background.
  - 5, 6, 7: black.
- Colour values: white = all ones; a primary channel is all ones or 0.
- Reset: asynchronous; all outputs go to their inactive or zero values (sync lines to their inactive level); state goes to IDLE; frame_cnt and offset go to 0; mode_q goes to 0. After reset release, the first frame starts on the cycle after enable is seen high.

Optional Feature:
- Macro LCD_TPG_LVDS_PACK_EN.
- When defined, add output lvds_data of width PPC*21. Each 21-bit word is packed from the top 6 bits of each colour (r,g,b below), using the registered syncs and de:
  - pair0 = {g[0], r[5:0]}
  - pair1 = {b[1:0], g[5:1]}
  - pair2 = {de, vsync, hsync, b[5:2]}
- lvds_data has the same latency as rgb.
- When the macro is undefined, the port and its logic are absent.

Decomposition:
- Shared package lcd_pkg holds:
  - pattern mode localparams: MODE_SOLID=0, MODE_BARS=1, MODE_GRAD=2, MODE_CHECK=3, MODE_MOVE=4, MODE_BLACK=5
  - the state encoding (IDLE, RUN, DRAIN)
  - the colour bar table
- Sub-module lcd_pattern_pixel: combinational x,y,mode,offset -> {r,g,b}, instantiated PPC times.

Test Plan:
- Use small timing: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, PPC=1, GRAD_SHIFT=1, CHK_SHIFT=2, so HT=24 and VT=8. With enable=1, require:
  - 16 de cycles per line, 4 de lines per frame
  - hsync low for 3 cycles starting 2 cycles after de falls
  - vsync low on lines 5 and 6
  - frame period of 192 cycles
- Mode 1 with H_ACTIVE=16 (BAR=2): x=0..1 gives white, x=2..3 gives yellow, x=14..15 gives black.
- Mode 2: x=5 gives rgb component 2. Mode 3: (x=4, y=0) gives white and (x=4, y=4) gives black.
- Change mode from 0 to 3 mid-frame: the pattern changes only at the next frame_start, and frame_cnt increments by 1 per frame.
- Deassert enable mid-frame: the frame completes, then busy=0 and outputs are idle. Reassert enable: frame_start occurs 2 cycles after enable is seen high.
- Assert rst_n low mid-line: all outputs become inactive asynchronously. With PPC=2 and HT=24, 12 clocks per line, and pixel 1 carries x=2*hcnt+1.
